// File: rtl/keep_one_in_n_unzip.sv
// Expands 32-bit words of four packed 8-bit IQ symbols (4-bit I/Q) into four
// 32-bit {I16, Q16} samples, one per output beat.
module keep_one_in_n_unzip #(
  parameter int WIDTH       = 32,
  parameter int EXPAND_MODE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready
);

  logic [WIDTH-1:0] word_reg;
  logic             last_reg;
  logic             full;
  logic [1:0]       idx;
  logic [7:0]       sym;
  logic             word_done;
  logic             in_beat;
  logic             out_beat;

  // Nibble lands in the MSBs so the 4-bit two's-complement sign carries over.
  function automatic logic [15:0] expand(input logic [3:0] nib);
    if (EXPAND_MODE == 1)
      return {nib, nib, nib, nib};
    else
      return {nib, 12'h000};
  endfunction

  always_comb begin
    sym = '0;
    case (idx)
      2'd0:    sym = word_reg[23:16];
      2'd1:    sym = word_reg[31:24];
      2'd2:    sym = word_reg[7:0];
      default: sym = word_reg[15:8];
    endcase
  end

  assign word_done = (idx == 2'd3);
  assign o_tdata   = {expand(sym[7:4]), expand(sym[3:0])};
  assign o_tvalid  = full;
  assign o_tlast   = full & last_reg & word_done;
  assign i_tready  = ~full | (word_done & o_tready);
  assign in_beat   = i_tvalid & i_tready;
  assign out_beat  = full & o_tready;

  // A load always wins over the final output beat so back-to-back words have no bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_reg <= '0;
      last_reg <= 1'b0;
      full     <= 1'b0;
      idx      <= '0;
    end else if (in_beat) begin
      word_reg <= i_tdata;
      last_reg <= i_tlast;
      full     <= 1'b1;
      idx      <= '0;
    end else if (out_beat) begin
      if (word_done) begin
        full <= 1'b0;
        idx  <= '0;
      end else begin
        idx <= idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_keep_one_in_n_unzip.sv
// Directed bench for keep_one_in_n_unzip: one instance per EXPAND_MODE, shared stimulus.
module tb_keep_one_in_n_unzip;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_tdata;
  logic        i_tlast, i_tvalid, o_tready;
  logic        i_tready0, i_tready1;
  logic [31:0] o_tdata0, o_tdata1;
  logic        o_tlast0, o_tlast1, o_tvalid0, o_tvalid1;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  keep_one_in_n_unzip #(.WIDTH(32), .EXPAND_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .i_tdata(i_tdata), .i_tlast(i_tlast),
    .i_tvalid(i_tvalid), .i_tready(i_tready0), .o_tdata(o_tdata0),
    .o_tlast(o_tlast0), .o_tvalid(o_tvalid0), .o_tready(o_tready)
  );

  keep_one_in_n_unzip #(.WIDTH(32), .EXPAND_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .i_tdata(i_tdata), .i_tlast(i_tlast),
    .i_tvalid(i_tvalid), .i_tready(i_tready1), .o_tdata(o_tdata1),
    .o_tlast(o_tlast1), .o_tvalid(o_tvalid1), .o_tready(o_tready)
  );

  typedef struct {
    logic [31:0] word;
    logic        last;
    logic        mode;
    logic [31:0] exp[4];
    logic [3:0]  exp_last;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference expansion: symbol k of a word sits in byte lane {2,3,0,1}[k].
  function automatic logic [32:0] model(input logic [31:0] w, input int unsigned k,
                                        input bit mode, input logic last);
    int unsigned lane[4] = '{2, 3, 0, 1};
    logic [31:0] b, ni, nq, d;
    b  = (w >> (8 * lane[k])) & 32'hFF;
    ni = b >> 4;
    nq = b & 32'hF;
    if (mode) d = ((ni * 32'h1111) << 16) | (nq * 32'h1111);
    else      d = (ni << 28) | (nq << 12);
    return {last && (k == 3), d};
  endfunction

  task automatic apply_vec(input int vi);
    vec_t v = vecs[vi];
    chk($sformatf("vec%0d_in_ready", vi), {31'b0, i_tready0}, 32'd1);
    i_tdata  = v.word;
    i_tlast  = v.last;
    i_tvalid = 1'b1;
    o_tready = 1'b1;
    step();
    i_tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("vec%0d_s%0d_valid", vi, k), {31'b0, v.mode ? o_tvalid1 : o_tvalid0}, 32'd1);
      chk($sformatf("vec%0d_s%0d_data", vi, k), v.mode ? o_tdata1 : o_tdata0, v.exp[k]);
      chk($sformatf("vec%0d_s%0d_last", vi, k), {31'b0, v.mode ? o_tlast1 : o_tlast0},
          {31'b0, v.exp_last[k]});
      step();
    end
    chk($sformatf("vec%0d_idle_after", vi), {31'b0, v.mode ? o_tvalid1 : o_tvalid0}, 32'd0);
  endtask

  task automatic run_stream(input int n, input bit rand_ready, input bit pkt_last,
                            output int valid_cycles, output int span,
                            output int rdy_while_full, output int beats);
    logic [31:0] words[$];
    logic [32:0] q0[$], q1[$];
    logic [32:0] e;
    logic [31:0] held0, held1;
    logic        held_last0;
    bit          stalled = 0;
    bit          done = 0;
    int          sent = 0;
    int          first_c = -1, last_c = -1;
    valid_cycles = 0; rdy_while_full = 0; beats = 0;
    for (int i = 0; i < n; i++) words.push_back($urandom);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      o_tready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      i_tvalid = (sent < n);
      i_tdata  = (sent < n) ? words[sent] : 32'h0;
      i_tlast  = pkt_last && (sent == n - 1);
      #1;
      if (stalled) begin
        chk("stall_hold_data0", o_tdata0, held0);
        chk("stall_hold_data1", o_tdata1, held1);
        chk("stall_hold_last", {31'b0, o_tlast0}, {31'b0, held_last0});
        chk("stall_hold_valid", {31'b0, o_tvalid0}, 32'd1);
      end
      if (o_tvalid0) begin
        valid_cycles++;
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        if (i_tready0) rdy_while_full++;
      end
      if (o_tvalid0 && o_tready) begin
        beats++;
        if (q0.size() == 0) chk("unexpected_sample", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          chk("stream_data0", o_tdata0, e[31:0]);
          chk("stream_last0", {31'b0, o_tlast0}, {31'b0, e[32]});
        end
        if (q1.size() != 0) begin
          e = q1.pop_front();
          chk("stream_data1", o_tdata1, e[31:0]);
        end
      end
      if (i_tvalid && i_tready0) begin
        for (int unsigned k = 0; k < 4; k++) begin
          q0.push_back(model(words[sent], k, 1'b0, i_tlast));
          q1.push_back(model(words[sent], k, 1'b1, i_tlast));
        end
        sent++;
      end
      stalled    = o_tvalid0 && !o_tready;
      held0      = o_tdata0;
      held1      = o_tdata1;
      held_last0 = o_tlast0;
      if (sent == n && q0.size() == 0) done = 1;
      step();
      if (done) break;
    end
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    if (!done) chk("stream_timeout", 32'd0, 32'd1);
    span = (first_c < 0) ? 0 : last_c - first_c + 1;
  endtask

  int vc, sp, rwf, bt;

  initial begin
    vecs[0] = '{word: 32'h12345678, last: 1'b0, mode: 1'b0,
                exp: '{32'h30004000, 32'h10002000, 32'h70008000, 32'h50006000}, exp_last: 4'b0000};
    vecs[1] = '{word: 32'h0000F0A5, last: 1'b1, mode: 1'b1,
                exp: '{32'h00000000, 32'h00000000, 32'hAAAA5555, 32'hFFFF0000}, exp_last: 4'b1000};
    vecs[2] = '{word: 32'hFFFF0000, last: 1'b1, mode: 1'b0,
                exp: '{32'hF000F000, 32'hF000F000, 32'h00000000, 32'h00000000}, exp_last: 4'b1000};
    vecs[3] = '{word: 32'h9C3E7B21, last: 1'b0, mode: 1'b1,
                exp: '{32'h3333EEEE, 32'h9999CCCC, 32'h22221111, 32'h7777BBBB}, exp_last: 4'b0000};
    vecs[4] = '{word: 32'h11111111, last: 1'b0, mode: 1'b0,
                exp: '{32'h10001000, 32'h10001000, 32'h10001000, 32'h10001000}, exp_last: 4'b0000};

    reset = 1'b1; i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b0;
    step(); step();
    chk("rst_valid", {31'b0, o_tvalid0}, 32'd0);
    chk("rst_last", {31'b0, o_tlast0}, 32'd0);
    chk("rst_data0", o_tdata0, 32'd0);
    chk("rst_data1", o_tdata1, 32'd0);
    chk("rst_ready", {31'b0, i_tready0}, 32'd1);
    reset = 1'b0;
    step();

    for (int i = 0; i < 4; i++) apply_vec(i);

    // Back-to-back words, no output backpressure.
    run_stream(3, 1'b0, 1'b0, vc, sp, rwf, bt);
    chk("b2b_valid_cycles", vc, 32'd12);
    chk("b2b_no_bubble_span", sp, 32'd12);
    chk("b2b_ready_while_full", rwf, 32'd3);
    chk("b2b_beats", bt, 32'd12);

    // 16-word packet, random backpressure.
    run_stream(16, 1'b1, 1'b1, vc, sp, rwf, bt);
    chk("pkt16_beats", bt, 32'd64);

    // Reset after two samples of a word.
    i_tdata = 32'hABCDEF01; i_tlast = 1'b1; i_tvalid = 1'b1; o_tready = 1'b1;
    step();
    i_tvalid = 1'b0;
    chk("abort_s0", o_tdata0, 32'hC000D000);
    step();
    chk("abort_s1", o_tdata0, 32'hA000B000);
    step();
    reset = 1'b1;
    #1;
    chk("abort_rst_valid", {31'b0, o_tvalid0}, 32'd0);
    chk("abort_rst_data", o_tdata0, 32'd0);
    chk("abort_rst_ready", {31'b0, i_tready0}, 32'd1);
    step(); step();
    reset = 1'b0;
    #1;
    chk("abort_post_valid", {31'b0, o_tvalid0}, 32'd0);
    apply_vec(4);

    // Hold o_tready low mid-word while another word is offered.
    i_tdata = 32'h12345678; i_tlast = 1'b0; i_tvalid = 1'b1; o_tready = 1'b1;
    step();
    i_tvalid = 1'b0;
    chk("hold_s0", o_tdata0, 32'h30004000);
    step();
    o_tready = 1'b0; i_tvalid = 1'b1; i_tdata = 32'hDEADBEEF;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("hold_c%0d_data", i), o_tdata0, 32'h10002000);
      chk($sformatf("hold_c%0d_valid", i), {31'b0, o_tvalid0}, 32'd1);
      chk($sformatf("hold_c%0d_in_ready", i), {31'b0, i_tready0}, 32'd0);
      step();
    end
    i_tvalid = 1'b0; o_tready = 1'b1;
    #1;
    chk("release_s1", o_tdata0, 32'h10002000);
    step();
    chk("release_s2", o_tdata0, 32'h70008000);
    step();
    chk("release_s3", o_tdata0, 32'h50006000);
    chk("release_s3_ready", {31'b0, i_tready0}, 32'd1);
    step();
    chk("release_idle", {31'b0, o_tvalid0}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/keep_one_in_n_unzip.md
Name: keep_one_in_n_unzip

Overview:
- Downstream expander for the 4-symbols-per-word compressed IQ stream.
- Accepts 32-bit packed words, each carrying 4 symbols of 8 bits (4-bit I in the high nibble, 4-bit Q in the low nibble).
- Emits 4 full-width 32-bit IQ samples per input word (16-bit I in [31:16], 16-bit Q in [15:0]).
- Sits in the receive RFNoC chain, restoring sample-rate data for the QPSK demod path.

Parameters:
- WIDTH, 32, data width of both input and output buses. Only 32 is supported.
- EXPAND_MODE, 0, nibble-to-16-bit rule. 0 = left-justify with zero fill; 1 = left-justify and replicate the nibble into all four nibble positions.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- i_tdata  input  WIDTH  packed word, 4 symbols
- i_tlast  input  1  end of packet on the packed stream
- i_tvalid  input  1  input valid
- i_tready  output  1  input ready
- o_tdata  output  WIDTH  expanded sample {I[15:0], Q[15:0]}
- o_tlast  output  1  end of packet on the expanded stream
- o_tvalid  output  1  output valid
- o_tready  input  1  output ready

Behaviour:
- Storage: word_reg[31:0], last_reg, full flag, 2-bit idx (symbol index 0..3).
- Reset (async, active-high): full=0, idx=0, word_reg=0, last_reg=0.
  - Outputs after reset: o_tvalid=0, o_tlast=0, o_tdata=0, i_tready=1.
- Symbol extraction order within a word (fixed):
  - idx0 = [23:16]
  - idx1 = [31:24]
  - idx2 = [7:0]
  - idx3 = [15:8]
- Expansion for byte b:
  - I nibble = b[7:4], Q nibble = b[3:0].
  - EXPAND_MODE 0: out = {nib, 12'h000}.
  - EXPAND_MODE 1: out = {nib, nib, nib, nib}.
  - The nibble is the MSBs of the result, so sign is preserved in both modes.
- o_tdata = {I16, Q16} of the byte selected by idx from word_reg. It is combinational from registers only; there is no path from i_tdata.
- o_tvalid = full.
- o_tlast = full & last_reg & (idx==3). Only the 4th sample of a word flagged last carries tlast.
- Output beat (o_tvalid & o_tready):
  - idx increments.
  - At idx==3 the beat ends the word: idx→0, full→0, unless reloaded the same cycle.
- i_tready = ~full | (idx==3 & o_tready).
  - This allows back-to-back words with no bubble.
  - i_tready depends combinationally on o_tready only, never on i_tvalid.
- Input beat (i_tvalid & i_tready):
  - Loads word_reg←i_tdata, last_reg←i_tlast, full←1, idx←0.
- Simultaneous final output beat and input beat: reload wins. full stays 1, idx=0, new word is presented next cycle.
- Latency: first expanded sample is valid the cycle after the input word is accepted.
- Throughput: sustained 1 input word per 4 cycles, 1 output sample per cycle.
- Backpressure: with o_tready=0, o_tdata, o_tlast, o_tvalid and idx hold stable. No sample is lost or duplicated.
- o_tvalid never deasserts without a completed beat (AXI-Stream compliant).
- Packet boundaries: no state carries across words beyond the full, idx and last_reg registers. A packet of N input words yields exactly 4N output samples.
- Reset mid-word: the current word is discarded, and the next accepted word starts at idx0.

Test Plan:
- Reset, then EXPAND_MODE=0, word 0x12345678 (tlast=0) with o_tready=1 -> 4 samples: 0x30004000, 0x10002000, 0x70008000, 0x50006000; o_tlast=0 on all.
- EXPAND_MODE=1, word 0x0000F0A5 tlast=1 -> samples 0x00000000, 0x00000000, 0xAAAA5555, 0xFFFF0000; o_tlast=1 only on the 4th sample.
- Continuous i_tvalid with 3 words and o_tready=1 -> exactly 12 consecutive o_tvalid cycles with no bubble; i_tready high only on the cycle of each word's 4th beat after the first load.
- Random o_tready toggling over a 16-word packet -> output data and tlast match the golden model, o_tdata is stable while o_tvalid=1 and o_tready=0, and 64 samples are output.
- Assert reset after 2 samples of a word, then send 0x11111111 -> outputs resume with 0x10001000 (mode 0); no stale samples from the aborted word.
- o_tready held 0 for 10 cycles mid-word -> idx frozen, i_tready=0, no input accepted; on release the remaining samples are emitted in order.
